gf180_ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the 512x32 byte-writable GF180 SRAM macro in the management SoC. Each requester presents a simple req/ack word access; the block registers all SRAM control pins, drives the active-low CEN/GWEN/WEN protocol, and returns read data one cycle after the SRAM clock edge. It sits between the CPU-side memory port (m0) and the DMA/housekeeping port (m1) and the single RAM instance.

---
 rtl/gf180_ram_arbiter.sv | 139 +++++++++++++
 tb/tb_gf180_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180_ram_arbiter.sv
// Two-requester round-robin sequencer for the 512x32 byte-writable GF180 SRAM macro.
// Serialises m0/m1 word accesses onto registered active-low SRAM pins; read data returns with ack.
module gf180_ram_arbiter (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [3:0]  m0_be,
   input  logic [8:0]  m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [3:0]  m1_be,
   input  logic [8:0]  m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        ram_cen,
   output logic        ram_gwen,
   output logic [3:0]  ram_wen,
   output logic [8:0]  ram_a,
   output logic [31:0] ram_d,
   input  logic [31:0] ram_q
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t      state, state_nxt;
   logic        last_grant, last_grant_nxt;
   logic        ram_cen_nxt, ram_gwen_nxt;
   logic [3:0]  ram_wen_nxt;
   logic [8:0]  ram_a_nxt;
   logic [31:0] ram_d_nxt;
   logic        m0_ack_nxt, m1_ack_nxt;

   logic        grant_en;
   logic        grant_sel;
   logic        sel_we;
   logic [3:0]  sel_be;
   logic [8:0]  sel_addr;
   logic [31:0] sel_wdata;

   // In RESP the just-served requester still shows its old request, so only the other one may win.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
      grant_en  = 1'b0;
      grant_sel = 1'b0;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) begin
               grant_en  = 1'b1;
               grant_sel = ~last_grant;
            end else if (m0_req || m1_req) begin
               grant_en  = 1'b1;
               grant_sel = m1_req;
            end
         end
         RESP: begin
            grant_en  = last_grant ? m0_req : m1_req;
            grant_sel = ~last_grant;
         end
         default: ;
      endcase
   end

   assign sel_we    = grant_sel ? m1_we    : m0_we;
   assign sel_be    = grant_sel ? m1_be    : m0_be;
   assign sel_addr  = grant_sel ? m1_addr  : m0_addr;
   assign sel_wdata = grant_sel ? m1_wdata : m0_wdata;

   // Control pins default to deselected, so CEN can only be low in the single ACCESS cycle.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      ram_cen_nxt    = 1'b1;
      ram_gwen_nxt   = 1'b1;
      ram_wen_nxt    = 4'hF;
      ram_a_nxt      = ram_a;
      ram_d_nxt      = ram_d;
      m0_ack_nxt     = 1'b0;
      m1_ack_nxt     = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (grant_en) begin
               state_nxt      = ACCESS;
               last_grant_nxt = grant_sel;
               ram_cen_nxt    = 1'b0;
               ram_gwen_nxt   = ~sel_we;
               ram_wen_nxt    = sel_we ? ~sel_be : 4'hF;
               ram_a_nxt      = sel_addr;
               ram_d_nxt      = sel_wdata;
            end else begin
               state_nxt = IDLE;
            end
         end
         ACCESS: begin
            state_nxt  = RESP;
            m0_ack_nxt = ~last_grant;
            m1_ack_nxt = last_grant;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         ram_cen    <= 1'b1;
         ram_gwen   <= 1'b1;
         ram_wen    <= 4'hF;
         ram_a      <= 9'h000;
         ram_d      <= 32'h0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         ram_cen    <= ram_cen_nxt;
         ram_gwen   <= ram_gwen_nxt;
         ram_wen    <= ram_wen_nxt;
         ram_a      <= ram_a_nxt;
         ram_d      <= ram_d_nxt;
         m0_ack     <= m0_ack_nxt;
         m1_ack     <= m1_ack_nxt;
      end
   end

   assign m0_rdata = ram_q;
   assign m1_rdata = ram_q;

endmodule

// File: tb/tb_gf180_ram_arbiter.sv
// Bench for gf180_ram_arbiter: behavioural SRAM macro, directed vector table,
// multi-cycle corner sequences and a randomized two-requester run against a memory model.
module tb_gf180_ram_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [3:0]  be    [2];
   logic [8:0]  addr  [2];
   logic [31:0] wdata [2];
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_cen, ram_gwen;
   logic [3:0]  ram_wen;
   logic [8:0]  ram_a;
   logic [31:0] ram_d;
   logic [31:0] ram_q;

   always #5 clk = ~clk;

   gf180_ram_arbiter dut (
      .clk      (clk),
      .resetn   (resetn),
      .m0_req   (req[0]),
      .m0_we    (we[0]),
      .m0_be    (be[0]),
      .m0_addr  (addr[0]),
      .m0_wdata (wdata[0]),
      .m0_ack   (m0_ack),
      .m0_rdata (m0_rdata),
      .m1_req   (req[1]),
      .m1_we    (we[1]),
      .m1_be    (be[1]),
      .m1_addr  (addr[1]),
      .m1_wdata (wdata[1]),
      .m1_ack   (m1_ack),
      .m1_rdata (m1_rdata),
      .ram_cen  (ram_cen),
      .ram_gwen (ram_gwen),
      .ram_wen  (ram_wen),
      .ram_a    (ram_a),
      .ram_d    (ram_d),
      .ram_q    (ram_q)
   );

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] lanes);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++)
         if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
      return res;
   endfunction

   // SRAM macro: acts on the rising edge while CEN is low; contents survive reset.
   logic [31:0] sram [512];
   always @(posedge clk) begin
      if (!ram_cen) begin
         if (!ram_gwen) sram[ram_a] <= merge_bytes(sram[ram_a], ram_d, ~ram_wen);
         else           ram_q       <= sram[ram_a];
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Protocol monitor: dual acks, CEN held low too long, and total ack pulses per port.
   int dual_ack = 0;
   int cen_run  = 0;
   int cen_long = 0;
   int ack_seen [2] = '{0, 0};
   int txn_done [2] = '{0, 0};
   always @(negedge clk) begin
      if (m0_ack && m1_ack) dual_ack++;
      if (m0_ack) ack_seen[0]++;
      if (m1_ack) ack_seen[1]++;
      if (!ram_cen) cen_run++;
      else cen_run = 0;
      if (cen_run > 1) cen_long++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ack_of(input int r);
      return (r == 0) ? m0_ack : m1_ack;
   endfunction

   function automatic logic [31:0] rdata_of(input int r);
      return (r == 0) ? m0_rdata : m1_rdata;
   endfunction

   task automatic set_fields(input int r, input logic t_we, input logic [3:0] t_be,
                             input logic [8:0] t_addr, input logic [31:0] t_wdata);
      we[r]    = t_we;
      be[r]    = t_be;
      addr[r]  = t_addr;
      wdata[r] = t_wdata;
   endtask

   // Reference model: a word array updated in completion order; reads must return its contents.
   logic [31:0] ref_mem [512];

   task automatic run_txn(input int r, input logic t_we, input logic [3:0] t_be,
                          input logic [8:0] t_addr, input logic [31:0] t_wdata);
      logic got_ack;
      set_fields(r, t_we, t_be, t_addr, t_wdata);
      req[r]  = 1'b1;
      got_ack = 1'b0;
      for (int w = 0; w < 16 && !got_ack; w++) begin
         step();
         if (ack_of(r)) got_ack = 1'b1;
      end
      if (!got_ack) begin
         check($sformatf("rnd_m%0d_ack_timeout", r), 32'h0, 32'h1);
      end else begin
         txn_done[r]++;
         if (t_we) ref_mem[t_addr] = merge_bytes(ref_mem[t_addr], t_wdata, t_be);
         else check($sformatf("rnd_m%0d_rd_%03h", r, t_addr), rdata_of(r), ref_mem[t_addr]);
      end
      req[r] = 1'b0;
   endtask

   task automatic drive_random(input int r);
      for (int n = 0; n < 40; n++) begin
         run_txn(r, 1'($urandom_range(0, 1)), 4'($urandom), 9'h100 | 9'($urandom_range(0, 15)),
                 $urandom);
         repeat ($urandom_range(0, 2)) step();
      end
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [3:0]  be;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_wen;
      logic        exp_gwen;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 4'hF, 9'h1A5, 32'hDEADBEEF, 32'h0,        4'h0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 4'h3, 9'h1A5, 32'h0,        32'hDEADBEEF, 4'hF, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 4'hF, 9'h000, 32'h11223344, 32'h0,        4'h0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 4'h5, 9'h000, 32'hAABBCCDD, 32'h0,        4'hA, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'hF, 9'h000, 32'h0,        32'h11BB33DD, 4'hF, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 4'h0, 9'h000, 32'hFFFFFFFF, 32'h0,        4'hF, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 4'hF, 9'h000, 32'h0,        32'h11BB33DD, 4'hF, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 4'hF, 9'h001, 32'h01010101, 32'h0,        4'h0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 4'hF, 9'h002, 32'h02020202, 32'h0,        4'h0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 4'hF, 9'h003, 32'h33333333, 32'h0,        4'h0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 4'hF, 9'h1A5, 32'h0,        32'hDEADBEEF, 4'hF, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 4'hC, 9'h002, 32'hABCD9999, 32'h0,        4'h3, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 4'hF, 9'h002, 32'h0,        32'hABCD0202, 4'hF, 1'b1};

      req    = 2'b00;
      we     = 2'b00;
      for (int r = 0; r < 2; r++) set_fields(r, 1'b0, 4'h0, 9'h000, 32'h0);

      // Reset held with m0 already requesting.
      resetn = 1'b0;
      set_fields(0, vecs[0].we, vecs[0].be, vecs[0].addr, vecs[0].wdata);
      req[0] = 1'b1;
      step();
      step();
      check("rst_cen",    32'(ram_cen),  32'h1);
      check("rst_gwen",   32'(ram_gwen), 32'h1);
      check("rst_wen",    32'(ram_wen),  32'hF);
      check("rst_a",      32'(ram_a),    32'h0);
      check("rst_d",      ram_d,         32'h0);
      check("rst_acks",   32'({m1_ack, m0_ack}), 32'h0);
      resetn = 1'b1;

      // Directed single-requester table: grant edge, SRAM edge, then idle.
      for (int k = 0; k < NV; k++) begin
         int r;
         r = int'(vecs[k].port);
         set_fields(r, vecs[k].we, vecs[k].be, vecs[k].addr, vecs[k].wdata);
         req[r] = 1'b1;
         step();
         check($sformatf("v%0d_cen_low", k), 32'(ram_cen),  32'h0);
         check($sformatf("v%0d_a", k),       32'(ram_a),    32'(vecs[k].addr));
         check($sformatf("v%0d_gwen", k),    32'(ram_gwen), 32'(vecs[k].exp_gwen));
         check($sformatf("v%0d_wen", k),     32'(ram_wen),  32'(vecs[k].exp_wen));
         check($sformatf("v%0d_no_ack", k),  32'({m1_ack, m0_ack}), 32'h0);
         if (vecs[k].we) check($sformatf("v%0d_d", k), ram_d, vecs[k].wdata);
         step();
         check($sformatf("v%0d_ack", k),     32'({m1_ack, m0_ack}), (r == 0) ? 32'h1 : 32'h2);
         check($sformatf("v%0d_cen_high", k), 32'(ram_cen), 32'h1);
         if (!vecs[k].we) check($sformatf("v%0d_rdata", k), rdata_of(r), vecs[k].exp_rdata);
         req[r] = 1'b0;
         txn_done[r]++;
         step();
         check($sformatf("v%0d_ack_done", k), 32'({m1_ack, m0_ack}), 32'h0);
      end

      // Contention from reset: m0 reads addr 1, m1 reads addr 2, both held high.
      resetn = 1'b0;
      set_fields(0, 1'b0, 4'hF, 9'h001, 32'h0);
      set_fields(1, 1'b0, 4'hF, 9'h002, 32'h0);
      req = 2'b11;
      step();
      resetn = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         logic e0, e1;
         step();
         e0 = (i == 2) || (i == 6);
         e1 = (i == 4) || (i == 8);
         check($sformatf("cont_c%0d_m0_ack", i), 32'(m0_ack), 32'(e0));
         check($sformatf("cont_c%0d_m1_ack", i), 32'(m1_ack), 32'(e1));
         if (e0) check($sformatf("cont_c%0d_m0_rdata", i), m0_rdata, 32'h01010101);
         if (e1) check($sformatf("cont_c%0d_m1_rdata", i), m1_rdata, 32'hABCD0202);
      end
      req = 2'b00;
      txn_done[0] += 2;
      txn_done[1] += 2;
      step();
      step();

      // Reset during the ACCESS cycle of an m1 write: access abandoned, no ack.
      set_fields(1, 1'b1, 4'hF, 9'h003, 32'hCAFEF00D);
      req[1] = 1'b1;
      step();
      check("midrst_cen_low", 32'(ram_cen), 32'h0);
      #2;
      resetn = 1'b0;
      #1;
      check("midrst_cen_async", 32'(ram_cen), 32'h1);
      check("midrst_wen_async", 32'(ram_wen), 32'hF);
      step();
      check("midrst_no_ack_a", 32'(m1_ack), 32'h0);
      step();
      check("midrst_no_ack_b", 32'(m1_ack), 32'h0);
      req[1] = 1'b0;
      resetn = 1'b1;
      step();
      set_fields(0, 1'b0, 4'hF, 9'h003, 32'h0);
      req[0] = 1'b1;
      step();
      step();
      check("midrst_rd_ack", 32'(m0_ack), 32'h1);
      check("midrst_rd_either", 32'(m0_rdata == 32'h33333333 || m0_rdata == 32'hCAFEF00D), 32'h1);
      req[0] = 1'b0;
      txn_done[0]++;
      step();

      // Fields change after the grant edge must not reach the SRAM.
      set_fields(0, 1'b0, 4'hF, 9'h1A5, 32'h0);
      req[0] = 1'b1;
      step();
      check("stab_a_granted", 32'(ram_a), 32'h1A5);
      addr[0]  = 9'h000;
      wdata[0] = 32'h12345678;
      we[0]    = 1'b1;
      step();
      check("stab_a_held", 32'(ram_a), 32'h1A5);
      check("stab_ack", 32'(m0_ack), 32'h1);
      check("stab_rdata", m0_rdata, 32'hDEADBEEF);
      req[0] = 1'b0;
      txn_done[0]++;
      step();

      // Randomized run: seed a 16-word window, then both requesters race against the model.
      for (int a = 0; a < 16; a++) run_txn(0, 1'b1, 4'hF, 9'h100 | 9'(a), $urandom);
      fork
         drive_random(0);
         drive_random(1);
      join
      step();
      step();

      check("mon_dual_ack", 32'(dual_ack), 32'h0);
      check("mon_cen_long", 32'(cen_long), 32'h0);
      check("mon_m0_ack_count", 32'(ack_seen[0]), 32'(txn_done[0]));
      check("mon_m1_ack_count", 32'(ack_seen[1]), 32'(txn_done[1]));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
